// File: rtl/spart.sv
// SPART core: chip-select register decode, baud divisor and 8N1 transmit/receive engines.
// All state is clocked on clk. The asynchronous active-high rst returns every register to its idle value.
module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] DIV_RESET = 16'd5208;
  localparam logic [15:0] DIV_MIN   = 16'd16;

  // Bus decode
  logic w_wr, w_rd, w_wr_hold, w_rd_rbuf, w_rd_stat;
  assign w_wr      = iocs & ~iorw;
  assign w_rd      = iocs & iorw;
  assign w_wr_hold = w_wr && (ioaddr == 2'b00);
  assign w_rd_rbuf = w_rd && (ioaddr == 2'b00);
  assign w_rd_stat = w_rd && (ioaddr == 2'b01);

  logic [15:0] r_div;
  logic [15:0] w_eff_div, w_eff_m1, w_half_m1;
  assign w_eff_div = (r_div < DIV_MIN) ? DIV_MIN : r_div;
  assign w_eff_m1  = w_eff_div - 16'd1;
  assign w_half_m1 = {1'b0, w_eff_div[15:1]} - 16'd1;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= DIV_RESET;
    end else if (w_wr && ioaddr == 2'b10) begin
      r_div[7:0] <= databus;
    end else if (w_wr && ioaddr == 2'b11) begin
      r_div[15:8] <= databus;
    end
  end

  // Transmit engine. r_tbr = 1 means the holding register is empty.
  state_t      r_tx_state, w_tx_next;
  logic [7:0]  r_hold, r_tx_shift;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic        r_tbr;
  logic        w_tx_end, w_tx_load;

  assign w_tx_end  = (r_tx_cnt == 16'd0);
  assign w_tx_load = !r_tbr && ((r_tx_state == S_IDLE) ||
                                (r_tx_state == S_STOP && w_tx_end));

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    w_tx_next = r_tx_state;
    txd       = 1'b1;
    case (r_tx_state)
      S_IDLE:  if (!r_tbr) w_tx_next = S_START;
      S_START: begin
        txd = 1'b0;
        if (w_tx_end) w_tx_next = S_DATA;
      end
      S_DATA: begin
        txd = r_tx_shift[0];
        if (w_tx_end && r_tx_bit == 3'd7) w_tx_next = S_STOP;
      end
      S_STOP:  if (w_tx_end) w_tx_next = r_tbr ? S_IDLE : S_START;
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold     <= 8'h00;
      r_tbr      <= 1'b1;
      r_tx_shift <= 8'h00;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
    end else begin
      if (w_tx_load) begin
        r_tx_shift <= r_hold;
        r_tx_cnt   <= w_eff_m1;
        r_tx_bit   <= 3'd0;
        r_tbr      <= 1'b1;
      end else begin
        if (w_wr_hold && r_tbr) begin
          r_hold <= databus;
          r_tbr  <= 1'b0;
        end
        // Divisor is resampled only at bit boundaries so a bit in flight keeps its length.
        if (r_tx_state != S_IDLE) begin
          if (w_tx_end) begin
            r_tx_cnt <= w_eff_m1;
            if (r_tx_state == S_DATA) begin
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
      end
    end
  end

  // Receive engine
  state_t      r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift, r_rbuf;
  logic        r_rda, r_ferr, r_ovr;
  logic        w_rx_tick, w_rx_done, w_rx_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx_tick = (r_rx_cnt == 16'd0);
  assign w_rx_done = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;
  assign w_rx_bad  = (r_rx_state == S_STOP) && w_rx_tick && !r_rx_s2;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (!r_rx_s2) w_rx_next = S_START;
      S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (r_rx_state == S_IDLE) begin
      r_rx_cnt <= w_half_m1;
      r_rx_bit <= 3'd0;
    end else if (w_rx_tick) begin
      r_rx_cnt <= w_eff_m1;
      if (r_rx_state == S_DATA) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt - 16'd1;
    end
  end

  // A completing byte beats a same-cycle buffer read: rda stays set, no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rbuf <= 8'h00;
      r_rda  <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_rx_done) begin
        r_rbuf <= r_rx_shift;
        r_rda  <= 1'b1;
      end else if (w_rd_rbuf) begin
        r_rda <= 1'b0;
      end
      if (w_rx_bad)        r_ferr <= 1'b1;
      else if (w_rd_stat)  r_ferr <= 1'b0;
      if (w_rx_done && r_rda && !w_rd_rbuf) r_ovr <= 1'b1;
      else if (w_rd_stat)                   r_ovr <= 1'b0;
    end
  end

  // Read mux and bus driver
  logic [7:0] w_rdata;
  always_comb begin
    w_rdata = 8'h00;
    case (ioaddr)
      2'b00: w_rdata = r_rbuf;
      2'b01: w_rdata = {4'b0000, r_ovr, r_ferr, r_rda, r_tbr};
      2'b10: w_rdata = r_div[7:0];
      2'b11: w_rdata = r_div[15:8];
      default: w_rdata = 8'h00;
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'hzz;
  assign rda     = r_rda;
  assign tbr     = r_tbr;

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: register map, TX framing, RX framing and error flags, reset.
// Expected serial bits and bytes come from a frame-level model ({stop, data, start}, LSB first).
module tb_spart;

  localparam int DIV = 16;

  logic       clk, rst, iocs, iorw, rxd;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr, txd;
  logic [7:0] tb_val;

  int n_checks = 0;
  int n_fail   = 0;

  assign databus = (iocs && iorw) ? 8'hzz : tb_val;

  spart dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_val = d;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #2 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Called at the negedge where the start bit is already on txd; returns at the next frame boundary.
  task automatic tx_frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? DIV / 2 : DIV) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, k), {7'b0, txd}, {7'b0, bits[k]});
    end
    repeat (DIV - DIV / 2) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic tx_single(input logic [7:0] b, input string tag);
    bus_write(2'b00, b);
    check({tag, "_tbr_low"}, {7'b0, tbr}, 8'h00);
    @(negedge clk);
    check({tag, "_tbr_back"}, {7'b0, tbr}, 8'h01);
    check({tag, "_start"}, {7'b0, txd}, 8'h00);
    tx_frame(b, tag);
    check({tag, "_idle"}, {7'b0, txd}, 8'h01);
  endtask

  initial begin
    logic [7:0]  b1, b2, d;
    logic [15:0] v;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; rxd = 1'b1;
    tb_val = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset_txd", {7'b0, txd}, 8'h01);
    rst = 1'b0;
    check("bus_idle_not_driven", databus, tb_val);
    read_check("reset_status", 2'b01, 8'h01);
    read_check("reset_div_lo", 2'b10, 8'h58);
    read_check("reset_div_hi", 2'b11, 8'h14);
    check("reset_rda", {7'b0, rda}, 8'h00);

    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom);
      bus_write(2'b10, v[7:0]);
      bus_write(2'b11, v[15:8]);
      read_check("div_rand_lo", 2'b10, v[7:0]);
      read_check("div_rand_hi", 2'b11, v[15:8]);
    end

    bus_write(2'b10, 8'h10);
    bus_write(2'b11, 8'h00);
    tx_single(8'hA5, "tx_a5");
    for (int i = 0; i < 2; i++) tx_single(8'($urandom), "tx_rand");

    // Divisor below the floor still yields 16-cycle bits
    bus_write(2'b10, 8'h08);
    read_check("div_small_readback", 2'b10, 8'h08);
    tx_single(8'($urandom), "tx_min_div");
    bus_write(2'b10, 8'h10);

    // Back-to-back frames; a third write while the holding register is full is dropped
    bus_write(2'b00, 8'h3C);
    @(negedge clk);
    check("b2b_start", {7'b0, txd}, 8'h00);
    fork
      tx_frame(8'h3C, "b2b_first");
      begin
        bus_write(2'b00, 8'hC3);
        check("b2b_tbr_busy", {7'b0, tbr}, 8'h00);
        repeat (20) @(negedge clk);
        bus_write(2'b00, 8'hFF);
        check("b2b_tbr_still_busy", {7'b0, tbr}, 8'h00);
      end
    join
    check("b2b_contiguous", {7'b0, txd}, 8'h00);
    check("b2b_tbr_reload", {7'b0, tbr}, 8'h01);
    tx_frame(8'hC3, "b2b_second");
    repeat (3 * DIV) @(negedge clk);
    check("b2b_third_dropped", {7'b0, txd}, 8'h01);
    check("b2b_tbr_idle", {7'b0, tbr}, 8'h01);

    // Receive path
    b1 = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) b1 = 8'($urandom);
      check("rx_rda_before", {7'b0, rda}, 8'h00);
      rx_frame(b1, 1'b1);
      @(negedge clk);
      check("rx_rda_set", {7'b0, rda}, 8'h01);
      read_check("rx_data", 2'b00, b1);
      check("rx_rda_cleared", {7'b0, rda}, 8'h00);
      repeat (5) @(negedge clk);
    end

    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("glitch_no_rda", {7'b0, rda}, 8'h00);
    read_check("glitch_status", 2'b01, 8'h01);

    rx_frame(8'($urandom), 1'b0);
    repeat (2 * DIV) @(negedge clk);
    check("ferr_no_rda", {7'b0, rda}, 8'h00);
    read_check("ferr_status", 2'b01, 8'h05);
    read_check("ferr_cleared", 2'b01, 8'h01);

    b1 = 8'($urandom);
    b2 = 8'($urandom);
    rx_frame(b1, 1'b1);
    rx_frame(b2, 1'b1);
    repeat (4) @(negedge clk);
    read_check("ovr_status", 2'b01, 8'h0B);
    read_check("ovr_data", 2'b00, b2);
    read_check("ovr_cleared", 2'b01, 8'h01);

    // Reset in the middle of a transmit frame
    bus_write(2'b00, 8'($urandom));
    repeat (40) @(negedge clk);
    bus_write(2'b00, 8'($urandom));
    check("rst_pre_tbr", {7'b0, tbr}, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("rst_txd_async", {7'b0, txd}, 8'h01);
    check("rst_tbr_async", {7'b0, tbr}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    read_check("rst_div_lo", 2'b10, 8'h58);
    read_check("rst_div_hi", 2'b11, 8'h14);
    read_check("rst_status", 2'b01, 8'h01);
    repeat (DIV) @(negedge clk);
    check("rst_txd_stays_idle", {7'b0, txd}, 8'h01);
    bus_read(2'b00, d);
    check("rst_rbuf", d, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
